// File: rtl/run_control_sequencer_if.sv
// Run-control bundle between the bench/top level and the sequencer.
// master = stimulus side, slave = sequencer side.
interface run_control_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             pause;
  logic             halt_req;
  logic             progress;
  logic             precharge;
  logic             run_en;
  logic             finish;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, pause, halt_req, progress,
    input  precharge, run_en, finish, done,
    input  timeout, cycle_count
  );

  modport slave (
    input  start, pause, halt_req, progress,
    output precharge, run_en, finish, done,
    output timeout, cycle_count
  );
endinterface

// File: rtl/run_control_sequencer.sv
// DataPath run controller: precharge -> run -> finish -> done.
// Optional watchdog on missing progress: define RUN_CTRL_WATCHDOG_EN.
module run_control_sequencer #(
  parameter int CNT_W            = 16,
  parameter int PRECHARGE_CYCLES = 2,
  parameter int MAX_CYCLES       = 225,
  parameter int FINISH_CYCLES    = 1,
  parameter int WDOG_CYCLES      = 32
) (
  input logic                  clk,
  input logic                  reset,
  run_control_sequencer_if.slave bus
);

  if (longint'(MAX_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_max
    $error("MAX_CYCLES does not fit in CNT_W bits");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    RUN,
    FINISH,
    DONE
  } state_t;

  localparam int PH_W     = 16;
  localparam int PRE_LAST =
    (PRECHARGE_CYCLES > 0) ? PRECHARGE_CYCLES - 1 : 0;
  localparam int FIN_LAST =
    (FINISH_CYCLES > 1) ? FINISH_CYCLES - 1 : 0;

  state_t           state;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic             pre_q;
  logic             fin_q;
  logic             done_q;
  logic             to_q;
  logic             budget_hit;
  logic             wdog_hit;

  assign count_nx   = count + CNT_W'(1);
  assign budget_hit = ~bus.pause &
                      (count_nx == CNT_W'(MAX_CYCLES));

`ifdef RUN_CTRL_WATCHDOG_EN
  logic [15:0] idle;
  logic [15:0] idle_nx;

  assign idle_nx  = idle + 16'd1;
  assign wdog_hit = ~bus.progress & ~bus.pause &
                    (idle_nx == 16'(WDOG_CYCLES));
`else
  logic unused_progress;

  assign unused_progress = bus.progress;
  assign wdog_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      phase  <= '0;
      count  <= '0;
      pre_q  <= 1'b0;
      fin_q  <= 1'b0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
      idle   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            count  <= '0;
            to_q   <= 1'b0;
            phase  <= '0;
            done_q <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
            idle   <= '0;
`endif
            if (PRECHARGE_CYCLES == 0) begin
              state <= RUN;
            end else begin
              state <= PRECHARGE;
              pre_q <= 1'b1;
            end
          end
        end
        PRECHARGE: begin
          if (phase == PH_W'(PRE_LAST)) begin
            state <= RUN;
            pre_q <= 1'b0;
            phase <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
            idle  <= '0;
`endif
          end else begin
            phase <= phase + 1'b1;
          end
        end
        RUN: begin
          if (~bus.pause) count <= count_nx;
`ifdef RUN_CTRL_WATCHDOG_EN
          if (bus.progress) idle <= '0;
          else if (~bus.pause) idle <= idle_nx;
`endif
          // halt wins over budget/watchdog; only timeout differs
          if (bus.halt_req | budget_hit | wdog_hit) begin
            state <= FINISH;
            fin_q <= 1'b1;
            phase <= '0;
            to_q  <= ~bus.halt_req;
          end
        end
        FINISH: begin
          if (phase == PH_W'(FIN_LAST)) begin
            state  <= DONE;
            fin_q  <= 1'b0;
            done_q <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.precharge   = pre_q;
  assign bus.finish      = fin_q;
  assign bus.done        = done_q;
  assign bus.timeout     = to_q;
  assign bus.cycle_count = count;
  assign bus.run_en      = (state == RUN) & ~bus.pause;

endmodule
